// File: rtl/crc16_frame_checker_pkg.sv
// Shared CRC definitions: checker state encoding and CCITT constants.
package crc_pkg;

  localparam int unsigned       CRC_W      = 16;
  localparam logic [CRC_W-1:0]  POLY_CCITT = 16'h1021;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC,
    DONE
  } chk_state_t;

endpackage

// File: rtl/crc16_lfsr_step.sv
// One serial step of the CRC-16 remainder register (x^16 term implicit).
module crc16_lfsr_step
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = POLY_CCITT
) (
  input  logic [CRC_W-1:0] rem,
  input  logic             bit_in,
  output logic [CRC_W-1:0] rem_next
);

  // Shift the new bit in and fold the polynomial back when the MSB falls out.
  always_comb begin
    rem_next = {rem[CRC_W-2:0], bit_in} ^ (rem[CRC_W-1] ? POLY : '0);
  end

endmodule

// File: rtl/crc16_frame_checker.sv
// Serial CRC-16 frame checker: DATA_W data bits then 16 CRC bits, MSB first.
// A frame is good when the remainder over data+CRC is zero.
module crc16_frame_checker
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY   = POLY_CCITT,
  parameter logic [CRC_W-1:0] INIT   = 16'h0000,
  parameter int unsigned      DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FRAME_START,
  input  logic              BIT_IN,
  input  logic              BIT_VALID,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              CRC_OK,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [CRC_W-1:0]  CRC_RX
);

  // Wide enough for both the data count and the 16-bit CRC count.
  localparam int unsigned CNT_W = ($clog2(DATA_W + 1) > $clog2(CRC_W)) ?
                                  $clog2(DATA_W + 1) : $clog2(CRC_W);

  chk_state_t        state;
  chk_state_t        st_cur;
  logic [CRC_W-1:0]  rem;
  logic [CRC_W-1:0]  rem_cur;
  logic [CRC_W-1:0]  rem_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_cur;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] data_sr_shift;
  logic [CRC_W-1:0]  crc_sr;
  logic [CRC_W-1:0]  crc_sr_shift;
  logic              frame_done_q;
  logic              crc_ok_q;
  logic [DATA_W-1:0] data_out_q;
  logic [CRC_W-1:0]  crc_rx_q;

  // FRAME_START re-arms in the same cycle, so a bit arriving with it is
  // treated as the first data bit of the fresh frame: present the
  // freshly-armed view of state/remainder/counter/shift regs to the update.
  always_comb begin
    st_cur        = FRAME_START ? DATA : state;
    rem_cur       = FRAME_START ? INIT : rem;
    cnt_cur       = FRAME_START ? '0   : cnt;
    data_sr_shift = FRAME_START ? '0   : data_sr;
    crc_sr_shift  = FRAME_START ? '0   : crc_sr;
    data_sr_shift = data_sr_shift << 1;
    data_sr_shift[0] = BIT_IN;
    crc_sr_shift  = crc_sr_shift << 1;
    crc_sr_shift[0] = BIT_IN;
  end

  crc16_lfsr_step #(
    .POLY (POLY)
  ) u_step (
    .rem      (rem_cur),
    .bit_in   (BIT_IN),
    .rem_next (rem_next)
  );

  // Frame sequencing, remainder/shift registers and result capture.
  // Results are captured on the edge accepting the last CRC bit so they are
  // already valid while FRAME_DONE is high.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      rem          <= INIT;
      cnt          <= '0;
      data_sr      <= '0;
      crc_sr       <= '0;
      frame_done_q <= 1'b0;
      crc_ok_q     <= 1'b0;
      data_out_q   <= '0;
      crc_rx_q     <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (FRAME_START) begin
        state   <= DATA;
        rem     <= INIT;
        cnt     <= '0;
        data_sr <= '0;
        crc_sr  <= '0;
      end
      case (st_cur)
        IDLE: begin
        end
        DATA: begin
          if (BIT_VALID) begin
            rem     <= rem_next;
            data_sr <= data_sr_shift;
            if (cnt_cur == CNT_W'(DATA_W - 1)) begin
              cnt   <= '0;
              state <= CRC;
            end else begin
              cnt   <= cnt_cur + 1'b1;
            end
          end
        end
        CRC: begin
          if (BIT_VALID) begin
            rem    <= rem_next;
            crc_sr <= crc_sr_shift;
            if (cnt_cur == CNT_W'(CRC_W - 1)) begin
              cnt          <= '0;
              state        <= DONE;
              frame_done_q <= 1'b1;
              crc_ok_q     <= (rem_next == '0);
              data_out_q   <= data_sr;
              crc_rx_q     <= crc_sr_shift;
            end else begin
              cnt <= cnt_cur + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign BUSY       = (state == DATA) || (state == CRC);
  assign FRAME_DONE = frame_done_q;
  assign CRC_OK     = crc_ok_q;
  assign DATA_OUT   = data_out_q;
  assign CRC_RX     = crc_rx_q;

endmodule
